// File: rtl/uf_somsub_cdb.sv
// Add/subtract functional unit with a common-data-bus style broadcast.
// Accepted requests wait in a small FIFO. A three-state controller takes
// each request through a fixed number of execution cycles. It then drives
// the result, destination address and reservation-station tag for exactly
// one cycle, marked by `done`.
module uf_somsub_cdb #(
    parameter int LATENCIA  = 3,   // execution cycles per operation, 1..15
    parameter int PROF_FILA = 2    // request FIFO depth
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic       pronto,
    input  logic [2:0] op,
    input  logic [8:0] regY,
    input  logic [8:0] regZ,
    input  logic [2:0] endX,
    input  logic [2:0] rotulo_in,
    output logic       done,
    output logic [8:0] resultado,
    output logic [2:0] enderecoX,
    output logic [2:0] rotulo_out,
    output logic       erro_op,
    output logic       perdido
);

    localparam int PW = (PROF_FILA > 1) ? $clog2(PROF_FILA) : 1;
    localparam int CW = $clog2(PROF_FILA + 1);

    localparam logic [2:0] OP_SOM = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    // A queued request: everything needed to execute and broadcast it.
    typedef struct packed {
        logic [2:0] op;
        logic [8:0] y;
        logic [8:0] z;
        logic [2:0] end_x;
        logic [2:0] rotulo;
    } pedido_t;

    typedef enum logic [1:0] {
        OCIOSO,
        EXECUTANDO,
        CONCLUIDO
    } estado_t;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    pedido_t         fila_q [PROF_FILA];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            push;
    logic            pop;
    pedido_t         entrada;

    // Wrap-around increment that also works for non-power-of-two depths.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(PROF_FILA - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // The ready signal depends only on the registered count. A pop on the
    // same edge does not raise it, which keeps it off any combinational path
    // from the controller.
    assign pronto = (count_q < CW'(PROF_FILA));
    assign push   = run && pronto;

    assign entrada = '{op: op, y: regY, z: regZ, end_x: endX, rotulo: rotulo_in};

    // Pointer and occupancy bookkeeping for the FIFO.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO control registers. The storage itself needs no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fila_q[wr_ptr_q] <= entrada;
        end
    end

    // ------------------------------------------------------------------
    // Execution controller
    // ------------------------------------------------------------------
    estado_t     estado_q, estado_d;
    logic [3:0]  cnt_q, cnt_d;
    pedido_t     oper_q, oper_d;
    logic        fim;          // last execution cycle: latch the broadcast
    logic        fila_vazia;

    assign fila_vazia = (count_q == '0);

    // Next-state logic. A pop loads the operation register and the down-counter.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        oper_d   = oper_q;
        pop      = 1'b0;
        fim      = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (!fila_vazia) begin
                    pop      = 1'b1;
                    oper_d   = fila_q[rd_ptr_q];
                    cnt_d    = 4'(LATENCIA - 1);
                    estado_d = EXECUTANDO;
                end
            end
            EXECUTANDO: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    fim      = 1'b1;
                    estado_d = CONCLUIDO;
                end
            end
            CONCLUIDO: begin
                if (!fila_vazia) begin
                    pop      = 1'b1;
                    oper_d   = fila_q[rd_ptr_q];
                    cnt_d    = 4'(LATENCIA - 1);
                    estado_d = EXECUTANDO;
                end else begin
                    estado_d = OCIOSO;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // Controller state, counter and operation register.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= OCIOSO;
            cnt_q    <= 4'd0;
            oper_q   <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            oper_q   <= oper_d;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and broadcast registers
    // ------------------------------------------------------------------
    logic [8:0] calc;
    logic       op_invalido;

    // Nine-bit wrap-around arithmetic. An unknown opcode yields zero.
    always_comb begin
        calc        = 9'd0;
        op_invalido = 1'b0;
        case (oper_q.op)
            OP_SOM:  calc = oper_q.y + oper_q.z;
            OP_SUB:  calc = oper_q.y - oper_q.z;
            default: op_invalido = 1'b1;
        endcase
    end

    logic [8:0] resultado_q;
    logic [2:0] endereco_q;
    logic [2:0] rotulo_q;
    logic       erro_q;
    logic       perdido_q;

    // Broadcast values load only on the last execution cycle and hold otherwise.
    // The error flag is pulsed so that it lines up with the done cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            resultado_q <= 9'd0;
            endereco_q  <= 3'd0;
            rotulo_q    <= 3'd0;
            erro_q      <= 1'b0;
        end else begin
            erro_q <= fim && op_invalido;
            if (fim) begin
                resultado_q <= calc;
                endereco_q  <= oper_q.end_x;
                rotulo_q    <= oper_q.rotulo;
            end
        end
    end

    // Sticky overflow flag: set when a request arrives while the FIFO is full.
    always_ff @(posedge clk) begin
        if (rst) begin
            perdido_q <= 1'b0;
        end else if (run && !pronto) begin
            perdido_q <= 1'b1;
        end
    end

    assign done       = (estado_q == CONCLUIDO);
    assign resultado  = resultado_q;
    assign enderecoX  = endereco_q;
    assign rotulo_out = rotulo_q;
    assign erro_op    = erro_q;
    assign perdido    = perdido_q;

endmodule

// File: tb/tb_uf_somsub_cdb.sv
// Bench for uf_somsub_cdb. It runs directed scenarios followed by random
// traffic. Every output is checked after every edge against a
// transaction-level reference: a queue of pending requests and the finish
// edge of the operation in flight.
module tb_uf_somsub_cdb;

    localparam int L     = 3;
    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst, run;
    logic       pronto;
    logic [2:0] op;
    logic [8:0] regY, regZ;
    logic [2:0] endX, rotulo_in;
    logic       done;
    logic [8:0] resultado;
    logic [2:0] enderecoX, rotulo_out;
    logic       erro_op, perdido;

    uf_somsub_cdb #(.LATENCIA(L), .PROF_FILA(DEPTH)) dut (
        .clk(clk), .rst(rst), .run(run), .pronto(pronto), .op(op),
        .regY(regY), .regZ(regZ), .endX(endX), .rotulo_in(rotulo_in),
        .done(done), .resultado(resultado), .enderecoX(enderecoX),
        .rotulo_out(rotulo_out), .erro_op(erro_op), .perdido(perdido)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int op; int y; int z; int x; int rot;
    } req_t;

    req_t q[$];
    req_t cur;
    bit   m_busy;
    int   m_fin;
    int   m_edge = 0;
    int   m_done, m_res, m_end, m_rot, m_err, m_perd;

    function automatic int compute(input req_t r);
        if (r.op == 0) return (r.y + r.z) % 512;
        if (r.op == 1) return (r.y - r.z + 512) % 512;
        return 0;
    endfunction

    // Applies one rising edge, using the input values that were present before it.
    task automatic model_edge();
        bit   ready;
        bit   avail;
        req_t r;
        if (rst) begin
            q.delete();
            m_busy = 0; m_done = 0; m_err = 0; m_perd = 0;
            m_res = 0; m_end = 0; m_rot = 0;
        end else begin
            ready  = (q.size() < DEPTH);
            m_done = 0;
            m_err  = 0;
            if (m_busy && m_edge == m_fin) begin
                m_done = 1;
                m_res  = compute(cur);
                m_end  = cur.x;
                m_rot  = cur.rot;
                m_err  = (cur.op > 1) ? 1 : 0;
            end
            avail = !m_busy || (m_edge == m_fin + 1);
            if (avail) begin
                if (q.size() > 0) begin
                    cur    = q.pop_front();
                    m_busy = 1;
                    m_fin  = m_edge + L;
                end else begin
                    m_busy = 0;
                end
            end
            if (run) begin
                if (ready) begin
                    r = '{op: int'(op), y: int'(regY), z: int'(regZ), x: int'(endX), rot: int'(rotulo_in)};
                    q.push_back(r);
                end else begin
                    m_perd = 1;
                end
            end
        end
        m_edge++;
    endtask

    // One clock cycle: drive inputs, take the edge, update the model, compare.
    task automatic tick(input bit r_rst, input bit r_run, input int r_op,
                        input int y, input int z, input int x, input int rt);
        rst = r_rst; run = r_run; op = 3'(r_op);
        regY = 9'(y); regZ = 9'(z); endX = 3'(x); rotulo_in = 3'(rt);
        @(posedge clk);
        model_edge();
        #1;
        check_val("done",       int'(done),       m_done);
        check_val("resultado",  int'(resultado),  m_res);
        check_val("enderecoX",  int'(enderecoX),  m_end);
        check_val("rotulo_out", int'(rotulo_out), m_rot);
        check_val("erro_op",    int'(erro_op),    m_err);
        check_val("perdido",    int'(perdido),    m_perd);
        check_val("pronto",     int'(pronto),     (q.size() < DEPTH) ? 1 : 0);
        if (done)
            $display("bcast t=%0t res=%0d endX=%0d rot=%0d err=%0d", $time, resultado, enderecoX, rotulo_out, erro_op);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; run = 0; op = 0; regY = 0; regZ = 0; endX = 0; rotulo_in = 0;
        #1;
        // Reset state
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(1, 1, 0, 9, 9, 1, 1);   // run during reset must be ignored
        check_val("rst_pronto", int'(pronto), 1);
        check_val("rst_done",   int'(done),   0);

        // Single SOM: accepted at edge 0, broadcast in the cycle after edge 4
        tick(0, 1, 0, 5, 7, 2, 1);
        idle(3);
        check_val("som_early_done", int'(done), 0);
        idle(1);
        check_val("som_done", int'(done),       1);
        check_val("som_res",  int'(resultado),  12);
        check_val("som_end",  int'(enderecoX),  2);
        check_val("som_rot",  int'(rotulo_out), 1);
        idle(1);
        check_val("som_hold", int'(resultado),  12);
        idle(2);

        // Wrap-around cases
        tick(0, 1, 1, 3, 5, 4, 2);
        idle(4);
        check_val("sub_wrap", int'(resultado), 510);
        tick(0, 1, 0, 511, 2, 5, 3);
        idle(4);
        check_val("som_wrap", int'(resultado), 1);
        idle(2);

        // Back-to-back burst from idle, then a burst while busy
        tick(0, 1, 0, 1, 1, 1, 0);
        tick(0, 1, 0, 2, 2, 1, 1);
        tick(0, 1, 0, 3, 3, 1, 2);
        tick(0, 1, 0, 4, 4, 1, 3);
        idle(16);
        tick(0, 1, 0, 1, 1, 0, 0);
        idle(1);
        tick(0, 1, 0, 1, 1, 1, 0);
        tick(0, 1, 0, 2, 2, 1, 1);
        tick(0, 1, 0, 3, 3, 1, 2);
        check_val("full_perdido", int'(perdido), 1);
        idle(16);

        // Invalid opcode, then a valid one
        tick(0, 1, 7, 100, 50, 6, 4);
        idle(4);
        check_val("inv_err", int'(erro_op),   1);
        check_val("inv_res", int'(resultado), 0);
        tick(0, 1, 1, 100, 50, 6, 5);
        idle(4);
        check_val("valid_err", int'(erro_op),   0);
        check_val("valid_res", int'(resultado), 50);
        idle(2);

        // Reset mid-operation, then a fresh request
        tick(0, 1, 0, 20, 30, 7, 6);
        idle(2);
        tick(1, 0, 0, 0, 0, 0, 0);
        check_val("midrst_perdido", int'(perdido), 0);
        idle(6);
        tick(0, 1, 0, 8, 9, 3, 7);
        idle(4);
        check_val("fresh_res", int'(resultado), 17);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit r_rst, r_run;
            int r_op;
            r_rst = ($urandom_range(0, 199) == 0);
            r_run = ($urandom_range(0, 99) < 45);
            r_op  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 7)) : int'($urandom_range(0, 1));
            tick(r_rst, r_run, r_op, int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end
        idle(12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
